// File: rtl/adder_pkg.sv
// adder_pkg: shared result type and PC-increment chain constants for ripple-carry adders
package adder_pkg;
    typedef struct packed {
        logic carry;
        logic sum;
    } result_t;
    localparam int   PC_ADDER_WIDTH = 30;
    localparam logic PC_CIN0        = 1'b1;
endpackage

// File: rtl/half_adder.sv
// half_adder: propagate/generate pair p = a ^ b, g = a & b
module half_adder (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);
    assign p = a ^ b;
    assign g = a & b;
endmodule

// File: rtl/full_adder.sv
// full_adder: combinational one-bit full adder with optional registered copy
// FULL_ADDER_REG_OUT_EN builds the SUM_R/COUT_R flops; otherwise they read 0.
module full_adder
    import adder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic SUM,
    output logic Cout,
    output logic SUM_R,
    output logic COUT_R
);
    logic    p1, g1, p2, g2;
    result_t res;
    half_adder u_ha_ab (.a(A),  .b(B),   .p(p1), .g(g1));
    half_adder u_ha_pc (.a(p1), .b(Cin), .p(p2), .g(g2));
    assign res  = '{carry: g1 | g2, sum: p2};
    assign SUM  = res.sum;
    assign Cout = res.carry;
`ifdef FULL_ADDER_REG_OUT_EN
    result_t res_q;
    always_ff @(posedge clk)
        res_q <= reset ? '0 : res;
    assign SUM_R  = res_q.sum;
    assign COUT_R = res_q.carry;
`else
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign SUM_R  = 1'b0;
    assign COUT_R = 1'b0;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed + random checks of full_adder and a 30-bit PC-style chain
module tb_full_adder;
    import adder_pkg::*;
`ifdef FULL_ADDER_REG_OUT_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif
    localparam int W = PC_ADDER_WIDTH;

    logic clk = 1'b0;
    logic reset, A, B, Cin, SUM, Cout, SUM_R, COUT_R;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_r;
    bit   r_valid = 1'b0;

    always #5 clk = ~clk;

    full_adder dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Cin(Cin),
        .SUM(SUM), .Cout(Cout), .SUM_R(SUM_R), .COUT_R(COUT_R)
    );

    logic [W-1:0] ca, cb, csum, unused_sr, unused_cr;
    logic [W:0]   cc;
    assign cc[0] = PC_CIN0;
    for (genvar i = 0; i < W; i++) begin : g_chain
        full_adder u_fa (
            .clk(clk), .reset(reset), .A(ca[i]), .B(cb[i]), .Cin(cc[i]),
            .SUM(csum[i]), .Cout(cc[i+1]), .SUM_R(unused_sr[i]), .COUT_R(unused_cr[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input vector; check combinational result at once and registered result after the edge.
    task automatic step(input logic a, input logic b, input logic c, input logic r, input string tag);
        logic [1:0] exp_sum;
        @(negedge clk);
        A = a; B = b; Cin = c; reset = r;
        exp_sum = 2'(a) + 2'(b) + 2'(c);
        #1;
        check({tag, " comb"}, {30'b0, Cout, SUM}, {30'b0, exp_sum});
        if (r_valid)
            check({tag, " reg_hold"}, {30'b0, COUT_R, SUM_R}, {30'b0, exp_r});
        @(posedge clk);
        #1;
        exp_r = REG_EN ? (r ? 2'b00 : exp_sum) : 2'b00;
        r_valid = 1'b1;
        check({tag, " reg"}, {30'b0, COUT_R, SUM_R}, {30'b0, exp_r});
    endtask

    task automatic chain(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W:0] exp;
        ca = a; cb = b;
        exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(PC_CIN0);
        #1;
        check(tag, {1'b0, cc[W], csum}, {1'b0, exp});
    endtask

    initial begin
        A = 0; B = 0; Cin = 0; reset = 1; ca = '0; cb = '0;
        step(1, 1, 1, 1, "reset_state");
        for (int i = 0; i < 8; i++)
            step(i[2], i[1], i[0], 0, "truth");
        step(1, 1, 1, 0, "reg_111");
        step(1, 0, 0, 1, "reset_mid");
        step(1, 0, 0, 0, "reset_release");
        for (int i = 0; i < 40; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, "rand");
        chain(30'd1234, 30'd0, "chain_1234");
        chain(30'd83648, 30'd1, "chain_83648");
        chain(30'd214748, 30'd248, "chain_214748");
        chain(30'd1, 30'd2, "chain_1_2");
        chain({W{1'b1}}, 30'd0, "chain_wrap");
        for (int i = 0; i < 20; i++)
            chain(W'($urandom), W'($urandom), "chain_rand");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
